fifo_wr: RTL and testbench
==========================

# fifo_wr

Write-side control for the asynchronous FIFO, the counterpart of the read-side pointer/empty block. It runs in the write clock domain and generates the SRAM write address and write enable. It maintains the binary and Gray write pointers, and derives full, fill level and almost-full from the Gray read pointer after it has been synchronized into this domain. The registered Gray pointer `wptr` goes to the 2-flop synchronizer that feeds the read domain.

## Interface

Parameters:
- `ADDR_WIDTH`, default 4. Pointer width including the wrap bit. Must be ≥ 2. FIFO depth is DEPTH = 2^(ADDR_WIDTH-1).
- `ALMOST_FULL_TH`, default 6. `walmost_full` asserts when the fill level is ≥ this value. Legal range 1..DEPTH.

Ports:
- `wclk`, input, 1. Write clock. One clock only.
- `wrst_n`, input, 1. Asynchronous, active-low reset.
- `winc`, input, 1. Write request, sampled on the rising edge of `wclk`.
- `wq2_rptr`, input, ADDR_WIDTH. Gray read pointer, already double-synchronized into `wclk`.
- `wovf_clr`, input, 1. Clears the sticky overflow flag.
- `wen`, output, 1. Memory write enable. Combinational: `winc & ~wfull`.
- `waddr`, output, ADDR_WIDTH-1. Memory write address: the low bits of the binary pointer.
- `wptr`, output, ADDR_WIDTH. Registered Gray write pointer, sent to the read-domain synchronizer.
- `wfull`, output, 1. Full flag, combinational from registers and `wq2_rptr`.
- `wlevel`, output, ADDR_WIDTH. Fill level, range 0..DEPTH.
- `walmost_full`, output, 1. High when `wlevel` ≥ `ALMOST_FULL_TH`.
- `woverflow`, output, 1. Sticky flag for a write attempted while full.

## Operation

- **State.** The block holds a binary pointer `wbin` of ADDR_WIDTH bits and the Gray pointer `wptr`.
  - On each edge, the next binary value is `wbin_next = wbin + wen`, wrapping modulo 2^ADDR_WIDTH.
  - `wptr` is loaded with `wbin_next ^ (wbin_next >> 1)` on the same edge. `wptr` is therefore always the Gray code of `wbin`, with no extra cycle of lag.
- **Full.** `wfull = (wptr == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]})`. In words: the two MSBs are inverted and the rest are equal.
- **Level.**
  - The read pointer is converted from Gray to binary: `rbin[i]` is the XOR of `wq2_rptr[MSB:i]`.
  - `wlevel = wbin - rbin`, modulo 2^ADDR_WIDTH.
  - `wlevel` equals DEPTH exactly when `wfull` = 1.
- **Pessimism.** Because `wq2_rptr` lags the real read pointer, `wfull` and `wlevel` are pessimistic: they may report fuller than the true state, never emptier. This is by design.
- **Write while full.** `wen` = 0, so pointers and address hold and the data is dropped. The overflow flag sets (see Configuration).
- **Overflow clear.** `wovf_clr` = 1 clears `woverflow` on the next edge. If a write-while-full occurs in the same cycle as `wovf_clr`, set wins.
- **Reset values.** Reset forces all registers to 0 asynchronously. Resulting outputs:
  - `wptr` = 0, `waddr` = 0, `wlevel` = 0.
  - `wfull` = 0, provided `wq2_rptr` = 0.
  - `walmost_full` = 0.
  - `woverflow` = 0.
  - `wen` follows `winc` (since `wfull` = 0).
- **Reset mid-operation.** Pointers return to 0 immediately. The read domain must be reset together with this block.

## Timing

- **Write acceptance.**
  - A write is accepted in the cycle where `winc` = 1 and `wfull` = 0.
  - The memory samples the data at `waddr` on that same edge, with `wen` = 1.
  - `waddr` and `wptr` advance on that edge.
- **Write to flags.** `wfull`, `wlevel` and `walmost_full` reflect an accepted write one cycle later. They reflect a read 2 `wclk` cycles after `rptr` changes in the read domain, because of the synchronizer.
- **Back-to-back writes.** One write per cycle is sustained until full.
- **Simultaneous write and read-pointer advance.** Both are reflected in the same cycle. The level changes by +1, −1 or 0, with no glitch requirement on the registered outputs.
- **Wrap-around.** After 2^ADDR_WIDTH accepted writes, `wbin` returns to 0. `waddr` wraps every DEPTH writes.

## Configuration

- Macro: `FIFO_WR_OVERFLOW_EN`.
- **Defined:** the `woverflow` sticky register and the `wovf_clr` logic are built as described in Operation.
- **Undefined:** `woverflow` is tied to 0, `wovf_clr` is ignored, and no register is inferred. Write-while-full is still dropped silently.

## Test plan

The tests below use defaults, ADDR_WIDTH = 4 and DEPTH = 8.

1. **Reset.** Assert `wrst_n` = 0 mid-stream after 3 writes → `wptr`, `waddr`, `wlevel` = 0 immediately. After release, `wfull` = 0 and `woverflow` = 0.
2. **Fill.** Hold `wq2_rptr` = 0 and issue 8 consecutive writes:
   - `waddr` steps 0..7.
   - `wptr` steps through Gray values 1, 3, 2, 6, 7, 5, 4, 12.
   - `walmost_full` = 1 after the 6th write.
   - `wfull` = 1 and `wlevel` = 8 after the 8th write.
3. **Overflow.** From full, drive `winc` = 1 for 2 cycles → `wen` = 0, `wptr` holds at 12, and `woverflow` = 1 on the next edge. Then:
   - Pulse `wovf_clr` → `woverflow` = 0.
   - Pulse `wovf_clr` while writing while full → `woverflow` stays 1.
4. **Drain.** From full, drive `wq2_rptr` to Gray(3) = 2 → `wfull` = 0, `wlevel` = 5, `walmost_full` = 0. The next write goes to `waddr` = 0.
5. **Wrap.** Run 20 writes while keeping `wq2_rptr` = Gray(`wbin` − 2) each cycle → `wlevel` stays ≤ 3, `wbin` wraps 15 → 0, and `wfull` never asserts.
6. **Macro off.** Build without `FIFO_WR_OVERFLOW_EN` and repeat scenario 3 → `woverflow` stays 0, and pointer behaviour is identical to the macro-on build.

Source files
------------

// File: rtl/fifo_wr.sv
// rtl/fifo_wr.sv - async FIFO write-side pointer, full, level and overflow control (option macro: FIFO_WR_OVERFLOW_EN)
module fifo_wr #(
    parameter int ADDR_WIDTH     = 4,
    parameter int ALMOST_FULL_TH = 6
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH-1:0] wq2_rptr,
    input  logic                  wovf_clr,
    output logic                  wen,
    output logic [ADDR_WIDTH-2:0] waddr,
    output logic [ADDR_WIDTH-1:0] wptr,
    output logic                  wfull,
    output logic [ADDR_WIDTH-1:0] wlevel,
    output logic                  walmost_full,
    output logic                  woverflow
);

    localparam logic [ADDR_WIDTH-1:0] AF_TH     = ADDR_WIDTH'(ALMOST_FULL_TH);
    // Inverting the two MSBs of the read Gray pointer gives the write pointer value at full.
    localparam logic [ADDR_WIDTH-1:0] FULL_MASK = ADDR_WIDTH'(3) << (ADDR_WIDTH - 2);

    logic [ADDR_WIDTH-1:0] wbin;
    logic [ADDR_WIDTH-1:0] wbin_next;
    logic [ADDR_WIDTH-1:0] wgray_next;
    logic [ADDR_WIDTH-1:0] rbin;

    assign wfull      = (wptr == (wq2_rptr ^ FULL_MASK));
    assign wen        = winc & ~wfull;
    assign wbin_next  = wbin + {{(ADDR_WIDTH-1){1'b0}}, wen};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign waddr      = wbin[ADDR_WIDTH-2:0];

    always_comb begin
        rbin = '0;
        rbin[ADDR_WIDTH-1] = wq2_rptr[ADDR_WIDTH-1];
        for (int i = ADDR_WIDTH - 2; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ wq2_rptr[i];
        end
    end

    assign wlevel       = wbin - rbin;
    assign walmost_full = (wlevel >= AF_TH);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin <= '0;
            wptr <= '0;
        end else begin
            wbin <= wbin_next;
            wptr <= wgray_next;
        end
    end

`ifdef FIFO_WR_OVERFLOW_EN
    // A dropped write in the same cycle as a clear keeps the flag set.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            woverflow <= 1'b0;
        end else if (winc && wfull) begin
            woverflow <= 1'b1;
        end else if (wovf_clr) begin
            woverflow <= 1'b0;
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = wovf_clr;
    assign woverflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr.sv
// tb/tb_fifo_wr.sv - directed self-checking bench for fifo_wr
module tb_fifo_wr;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic       winc;
    logic [3:0] wq2_rptr;
    logic       wovf_clr;
    logic       wen;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       wfull;
    logic [3:0] wlevel;
    logic       walmost_full;
    logic       woverflow;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef FIFO_WR_OVERFLOW_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    fifo_wr #(.ADDR_WIDTH(4), .ALMOST_FULL_TH(6)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .wovf_clr     (wovf_clr),
        .wen          (wen),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .wlevel       (wlevel),
        .walmost_full (walmost_full),
        .woverflow    (woverflow)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #2;
    endtask

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [3:0] fill_gray [8] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
    logic [3:0] model_wbin;

    initial begin
        wrst_n   = 1'b0;
        winc     = 1'b0;
        wq2_rptr = 4'd0;
        wovf_clr = 1'b0;
        #12;
        check("rst_wptr", wptr, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wlevel", wlevel, 0);
        check("rst_wfull", wfull, 0);
        check("rst_wovf", woverflow, 0);
        wrst_n = 1'b1;
        winc   = 1'b1;
        #1;
        check("wen_follows_winc", wen, 1);

        // three writes, then reset mid-stream
        tick(); tick(); tick();
        check("pre_rst_waddr", waddr, 3);
        check("pre_rst_wptr", wptr, 2);
        check("pre_rst_wlevel", wlevel, 3);
        wrst_n = 1'b0;
        #1;
        check("midrst_wptr", wptr, 0);
        check("midrst_waddr", waddr, 0);
        check("midrst_wlevel", wlevel, 0);
        winc = 1'b0;
        #1;
        wrst_n = 1'b1;
        #1;
        check("post_rst_wfull", wfull, 0);
        check("post_rst_wovf", woverflow, 0);

        // fill with read pointer held at 0
        winc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("fill_waddr", waddr, i);
            check("fill_wen", wen, 1);
            tick();
            check("fill_wptr", wptr, fill_gray[i]);
            check("fill_wlevel", wlevel, i + 1);
            check("fill_almost", walmost_full, (i + 1 >= 6) ? 1 : 0);
            check("fill_wfull", wfull, (i == 7) ? 1 : 0);
        end

        // write attempts while full
        #1;
        check("ovf_wen", wen, 0);
        tick();
        check("ovf_wptr1", wptr, 12);
        check("ovf_waddr", waddr, 0);
        check("ovf_flag", woverflow, OVF_ON);
        tick();
        check("ovf_wptr2", wptr, 12);
        check("ovf_level", wlevel, 8);
        winc     = 1'b0;
        wovf_clr = 1'b1;
        tick();
        check("ovf_cleared", woverflow, 0);
        winc = 1'b1;
        tick();
        check("ovf_set_wins", woverflow, OVF_ON);
        check("ovf_wptr3", wptr, 12);
        winc = 1'b0;
        tick();
        wovf_clr = 1'b0;
        check("ovf_clr2", woverflow, 0);

        // drain: reader has consumed three entries
        wq2_rptr = 4'd2;
        #1;
        check("drain_wfull", wfull, 0);
        check("drain_wlevel", wlevel, 5);
        check("drain_almost", walmost_full, 0);
        winc = 1'b1;
        #1;
        check("drain_wen", wen, 1);
        check("drain_waddr", waddr, 0);
        tick();
        check("drain_waddr_next", waddr, 1);
        check("drain_wlevel_next", wlevel, 6);

        // wrap with reader trailing two entries behind
        model_wbin = 4'd9;
        for (int i = 0; i < 20; i++) begin
            wq2_rptr = gray(model_wbin - 4'd2);
            #1;
            check("wrap_wfull", wfull, 0);
            check("wrap_wlevel_pre", wlevel, 2);
            tick();
            model_wbin = model_wbin + 4'd1;
            check("wrap_wptr", wptr, gray(model_wbin));
            check("wrap_wlevel_post", wlevel, 3);
        end
        check("wrap_waddr_end", waddr, 5);
        check("wrap_wptr_end", wptr, 4'd11);

        winc = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
